// File: rtl/weight_stream_sender.sv
// AXI4-Stream master that serializes one wide weight vector into MSB-first beats, zero-padded in the LSBs.
// Optional trailing XOR checksum beat when WEIGHT_STREAM_CHECKSUM_EN is defined.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; outputs quiet
// SEND   | presenting data beats, shifting on each handshake
// CHKSUM | presenting the XOR of all data beats (checksum build only)
module weight_stream_sender #(
  parameter  int KERNEL_SIZE   = 16,
  parameter  int WEIGHT_WIDTH  = 8,
  parameter  int BUS_WIDTH     = 32,
  localparam int REQUIRED_BITS = KERNEL_SIZE * KERNEL_SIZE * WEIGHT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [REQUIRED_BITS-1:0] weights_in,
  input  logic                     start,
  output logic [BUS_WIDTH-1:0]     m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic                     busy,
  output logic                     done
);

  localparam int NUM_TRANSFERS = (REQUIRED_BITS + BUS_WIDTH - 1) / BUS_WIDTH;
  localparam int PADDED_SIZE   = NUM_TRANSFERS * BUS_WIDTH;
  localparam int PAD_BITS      = PADDED_SIZE - REQUIRED_BITS;
  localparam int CNT_W         = $clog2(NUM_TRANSFERS) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_TRANSFERS - 1);

`ifdef WEIGHT_STREAM_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, SEND, CHKSUM} state_t;
`else
  typedef enum logic [0:0] {IDLE, SEND} state_t;
`endif

  state_t state, state_nxt;

  logic [PADDED_SIZE-1:0] shreg;
  logic [PADDED_SIZE-1:0] load_vec;
  logic [CNT_W-1:0]       cnt;
  logic [BUS_WIDTH-1:0]   cur_beat;
  logic                   load;
  logic                   beat_fire;
  logic                   last_fire;
`ifdef WEIGHT_STREAM_CHECKSUM_EN
  logic [BUS_WIDTH-1:0]   acc;
`endif

  // Left-justify the vector so the zero padding lands in the LSBs of the final beat.
  assign load_vec = PADDED_SIZE'(weights_in) << PAD_BITS;
  assign cur_beat = shreg[PADDED_SIZE-1 -: BUS_WIDTH];

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    load          = 1'b0;
    beat_fire     = 1'b0;
    last_fire     = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tdata  = '0;
    busy          = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = cur_beat;
`ifndef WEIGHT_STREAM_CHECKSUM_EN
        m_axis_tlast  = (cnt == LAST_CNT);
`endif
        if (m_axis_tready) begin
          beat_fire = 1'b1;
          if (cnt == LAST_CNT) begin
`ifdef WEIGHT_STREAM_CHECKSUM_EN
            state_nxt = CHKSUM;
`else
            state_nxt = IDLE;
            last_fire = 1'b1;
`endif
          end
        end
      end
`ifdef WEIGHT_STREAM_CHECKSUM_EN
      CHKSUM: begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = 1'b1;
        m_axis_tdata  = acc;
        if (m_axis_tready) begin
          state_nxt = IDLE;
          last_fire = 1'b1;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      shreg <= '0;
      cnt   <= '0;
      done  <= 1'b0;
`ifdef WEIGHT_STREAM_CHECKSUM_EN
      acc   <= '0;
`endif
    end else begin
      done <= last_fire;
      if (load) begin
        shreg <= load_vec;
        cnt   <= '0;
`ifdef WEIGHT_STREAM_CHECKSUM_EN
        acc   <= '0;
`endif
      end else if (beat_fire) begin
        shreg <= shreg << BUS_WIDTH;
        cnt   <= (cnt == LAST_CNT) ? '0 : cnt + CNT_W'(1);
`ifdef WEIGHT_STREAM_CHECKSUM_EN
        acc   <= acc ^ cur_beat;
`endif
      end
    end
  end

endmodule
